// File: rtl/tetris_board_ctrl.sv
// Tetris playfield: locked-cell grid, piece collision flags, row clearing FSM,
// saturating score and per-pixel occupancy for the VGA colour mux.
module tetris_board_ctrl #(
    parameter int COLS     = 10,
    parameter int ROWS     = 12,
    parameter int CELL_PX  = 40,
    parameter int SCORE_W  = 16,
    parameter int LINE_PTS = 1
) (
    input  logic               VGA_CLK_n,
    input  logic               iRST_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [19:0]        pc_col,
    input  logic [19:0]        pc_row,
    input  logic               lock_req,
    output logic               busy,
    output logic               col_down,
    output logic               col_left,
    output logic               col_right,
    output logic               cell_on,
    output logic               lines_pulse,
    output logic [2:0]         lines_cnt,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    typedef enum logic [2:0] {IDLE, LOCK, SCAN, SHIFT, DONE} state_t;

    localparam logic [5:0]           COLS_W    = 6'(COLS);
    localparam logic [5:0]           ROWS_W    = 6'(ROWS);
    localparam logic [10:0]          X_LIM     = 11'(COLS * CELL_PX);
    localparam logic [10:0]          Y_LIM     = 11'(ROWS * CELL_PX);
    localparam logic [9:0]           CPX       = 10'(CELL_PX);
    localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;
    localparam logic [SCORE_W+31:0]  PTS_W     = (SCORE_W + 32)'(LINE_PTS);

    state_t                    state, state_nxt;
    logic [ROWS-1:0][COLS-1:0] grid;
    logic [4:0]                scan_row;
    logic [4:0]                shift_row;
    logic [2:0]                line_cnt;
    logic                      cd_q, cl_q, cr_q;
    logic                      cd_nxt, cl_nxt, cr_nxt;
    logic                      scan_full;
    logic                      pix_hit;
    logic [9:0]                cell_x, cell_y;
    logic [SCORE_W+31:0]       score_sum;

    assign busy      = (state != IDLE);
    assign col_down  = cd_q | busy;
    assign col_left  = cl_q | busy;
    assign col_right = cr_q | busy;

    assign cell_x    = x / CPX;
    assign cell_y    = y / CPX;
    assign score_sum = (SCORE_W + 32)'(score) + (SCORE_W + 32)'(line_cnt) * PTS_W;

    // Neighbour lookups are done by matching every stored cell, so no index can leave the grid.
    always_comb begin
        cd_nxt = 1'b0;
        cl_nxt = 1'b0;
        cr_nxt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ({1'b0, pc_col[5*k +: 5]} >= COLS_W || {1'b0, pc_row[5*k +: 5]} >= ROWS_W) begin
                cd_nxt = 1'b1;
                cl_nxt = 1'b1;
                cr_nxt = 1'b1;
            end else begin
                if ({1'b0, pc_row[5*k +: 5]} + 6'd1 >= ROWS_W) cd_nxt = 1'b1;
                if (pc_col[5*k +: 5] == 5'd0) cl_nxt = 1'b1;
                if ({1'b0, pc_col[5*k +: 5]} + 6'd1 >= COLS_W) cr_nxt = 1'b1;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (grid[r][c]) begin
                            if ({1'b0, pc_row[5*k +: 5]} + 6'd1 == 6'(r) && pc_col[5*k +: 5] == 5'(c))
                                cd_nxt = 1'b1;
                            if (pc_row[5*k +: 5] == 5'(r) && {1'b0, pc_col[5*k +: 5]} == 6'(c + 1))
                                cl_nxt = 1'b1;
                            if (pc_row[5*k +: 5] == 5'(r) && {1'b0, pc_col[5*k +: 5]} + 6'd1 == 6'(c))
                                cr_nxt = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        scan_full = 1'b0;
        pix_hit   = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (scan_row == 5'(r)) scan_full = &grid[r];
        end
        if ({1'b0, x} < X_LIM && {1'b0, y} < Y_LIM) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (cell_y == 10'(r) && cell_x == 10'(c)) pix_hit = grid[r][c];
                end
            end
        end
    end

    always_ff @(posedge VGA_CLK_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lock_req) state_nxt = LOCK;
            LOCK:    state_nxt = SCAN;
            SCAN: begin
                if (scan_full)            state_nxt = SHIFT;
                else if (scan_row == 5'd0) state_nxt = DONE;
            end
            SHIFT:   if (shift_row == 5'd0) state_nxt = SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge VGA_CLK_n) begin
        if (!iRST_n) begin
            grid        <= '0;
            scan_row    <= '0;
            shift_row   <= '0;
            line_cnt    <= '0;
            lines_cnt   <= '0;
            lines_pulse <= 1'b0;
            score       <= '0;
            game_over   <= 1'b0;
            cd_q        <= 1'b0;
            cl_q        <= 1'b0;
            cr_q        <= 1'b0;
            cell_on     <= 1'b0;
        end else begin
            cd_q        <= cd_nxt;
            cl_q        <= cl_nxt;
            cr_q        <= cr_nxt;
            cell_on     <= pix_hit;
            lines_pulse <= 1'b0;
            case (state)
                LOCK: begin
                    for (int k = 0; k < 4; k++) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                if (pc_row[5*k +: 5] == 5'(r) && pc_col[5*k +: 5] == 5'(c))
                                    grid[r][c] <= 1'b1;
                            end
                        end
                        if (pc_row[5*k +: 5] == 5'd0 && {1'b0, pc_col[5*k +: 5]} < COLS_W)
                            game_over <= 1'b1;
                    end
                    scan_row <= 5'(ROWS - 1);
                    line_cnt <= '0;
                end
                SCAN: begin
                    if (scan_full)              shift_row <= scan_row;
                    else if (scan_row != 5'd0)  scan_row  <= scan_row - 5'd1;
                end
                // scan_row is left alone so the row that slid into it is tested again.
                SHIFT: begin
                    for (int r = 1; r < ROWS; r++) begin
                        if (shift_row == 5'(r)) grid[r] <= grid[r-1];
                    end
                    if (shift_row == 5'd0) begin
                        grid[0]  <= '0;
                        line_cnt <= line_cnt + 3'd1;
                    end else begin
                        shift_row <= shift_row - 5'd1;
                    end
                end
                DONE: begin
                    lines_cnt   <= line_cnt;
                    lines_pulse <= (line_cnt != 3'd0);
                    if (score_sum > {32'd0, SCORE_MAX}) score <= SCORE_MAX;
                    else                                score <= score_sum[SCORE_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_board_ctrl.sv
// Scoreboard bench for tetris_board_ctrl: default 10x12 board plus a small
// 6x8 board with a 3-bit score to exercise saturation.
module tb_tetris_board_ctrl;

    localparam int COLS = 10;
    localparam int ROWS = 12;
    localparam int CPX  = 40;

    logic        VGA_CLK_n = 1'b0;
    logic        iRST_n    = 1'b0;
    logic [9:0]  x         = '0;
    logic [9:0]  y         = '0;
    logic [19:0] pc_col    = '0;
    logic [19:0] pc_row    = '0;
    logic        lock_req0 = 1'b0;
    logic        lock_req1 = 1'b0;

    logic        busy0, col_down0, col_left0, col_right0, cell_on0, lines_pulse0, game_over0;
    logic [2:0]  lines_cnt0;
    logic [15:0] score0;
    logic        busy1, col_down1, col_left1, col_right1, cell_on1, lines_pulse1, game_over1;
    logic [2:0]  lines_cnt1;
    logic [2:0]  score1;

    int checks = 0;
    int errors = 0;
    int cur_c[4];
    int cur_r[4];
    bit mdl[ROWS][COLS];
    bit mdl_go = 1'b0;
    int mdl_score = 0;
    int q_lines0[$];
    int q_score0[$];
    int q_lines1[$];
    int q_score1[$];
    int q_flags[$];

    tetris_board_ctrl #(.COLS(COLS), .ROWS(ROWS), .CELL_PX(CPX), .SCORE_W(16), .LINE_PTS(1)) dut0 (
        .VGA_CLK_n(VGA_CLK_n), .iRST_n(iRST_n), .x(x), .y(y), .pc_col(pc_col), .pc_row(pc_row),
        .lock_req(lock_req0), .busy(busy0), .col_down(col_down0), .col_left(col_left0),
        .col_right(col_right0), .cell_on(cell_on0), .lines_pulse(lines_pulse0),
        .lines_cnt(lines_cnt0), .score(score0), .game_over(game_over0)
    );

    tetris_board_ctrl #(.COLS(6), .ROWS(8), .CELL_PX(CPX), .SCORE_W(3), .LINE_PTS(3)) dut1 (
        .VGA_CLK_n(VGA_CLK_n), .iRST_n(iRST_n), .x(x), .y(y), .pc_col(pc_col), .pc_row(pc_row),
        .lock_req(lock_req1), .busy(busy1), .col_down(col_down1), .col_left(col_left1),
        .col_right(col_right1), .cell_on(cell_on1), .lines_pulse(lines_pulse1),
        .lines_cnt(lines_cnt1), .score(score1), .game_over(game_over1)
    );

    always #5 VGA_CLK_n = ~VGA_CLK_n;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge VGA_CLK_n);
        #1;
    endtask

    function automatic int busyOf(input int inst);
        return (inst == 0) ? int'(busy0) : int'(busy1);
    endfunction

    function automatic int flagsOf(input int inst);
        if (inst == 0) return int'({col_down0, col_left0, col_right0});
        return int'({col_down1, col_left1, col_right1});
    endfunction

    function automatic bit mdlGet(input int r, input int c);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
        return mdl[r][c];
    endfunction

    task automatic setPiece(input int c0, input int r0, input int c1, input int r1,
                            input int c2, input int r2, input int c3, input int r3);
        cur_c = '{c0, c1, c2, c3};
        cur_r = '{r0, r1, r2, r3};
        for (int k = 0; k < 4; k++) begin
            pc_col[5*k +: 5] = 5'(cur_c[k]);
            pc_row[5*k +: 5] = 5'(cur_r[k]);
        end
    endtask

    // Expected {down,left,right} from the reference grid, compared one cycle later.
    task automatic applyStimulus(input string tag);
        int e;
        e = 0;
        for (int k = 0; k < 4; k++) begin
            if (cur_c[k] >= COLS || cur_r[k] >= ROWS) e = 7;
            else begin
                if (cur_r[k] + 1 >= ROWS || mdlGet(cur_r[k] + 1, cur_c[k])) e |= 4;
                if (cur_c[k] == 0 || mdlGet(cur_r[k], cur_c[k] - 1))        e |= 2;
                if (cur_c[k] + 1 >= COLS || mdlGet(cur_r[k], cur_c[k] + 1)) e |= 1;
            end
        end
        q_flags.push_back(e);
        tick();
        checkOutput(tag, flagsOf(0), q_flags.pop_front());
    endtask

    // Reference lock: write cells, then drop full rows bottom-up; cost counts the
    // extra busy cycles each clear adds (one scan hit plus r+1 shift steps).
    task automatic mdlLock(output int n, output int cost);
        int  r;
        bit  full;
        n    = 0;
        cost = 0;
        for (int k = 0; k < 4; k++) begin
            if (cur_c[k] < COLS && cur_r[k] < ROWS) begin
                mdl[cur_r[k]][cur_c[k]] = 1'b1;
                if (cur_r[k] == 0) mdl_go = 1'b1;
            end
        end
        r = ROWS - 1;
        while (r >= 0) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (!mdl[r][c]) full = 1'b0;
            if (full) begin
                for (int rr = r; rr > 0; rr--)
                    for (int c = 0; c < COLS; c++) mdl[rr][c] = mdl[rr-1][c];
                for (int c = 0; c < COLS; c++) mdl[0][c] = 1'b0;
                n++;
                cost += r + 2;
            end else begin
                r--;
            end
        end
        if (n > 0) begin
            mdl_score = (mdl_score + n > 65535) ? 65535 : mdl_score + n;
            q_lines0.push_back(n);
            q_score0.push_back(mdl_score);
        end
    endtask

    task automatic startLock(input int inst);
        if (inst == 0) lock_req0 = 1'b1;
        else           lock_req1 = 1'b1;
        tick();
        lock_req0 = 1'b0;
        lock_req1 = 1'b0;
    endtask

    task automatic waitIdle(input int inst, input int exp_len);
        int blen;
        blen = 0;
        while (busyOf(inst) != 0 && blen < 1000) begin
            if (blen == 1) checkOutput("stall_flags", flagsOf(inst), 7);
            blen++;
            tick();
        end
        if (blen >= 1000) checkOutput("busy_timeout", 1, 0);
        else              checkOutput("busy_len", blen, exp_len);
    endtask

    task automatic lockPiece();
        int n, cost;
        startLock(0);
        mdlLock(n, cost);
        waitIdle(0, 2 + ROWS + cost);
        checkOutput("lines_cnt", int'(lines_cnt0), n);
        checkOutput("score", int'(score0), mdl_score);
        checkOutput("game_over", int'(game_over0), int'(mdl_go));
    endtask

    task automatic checkPixel(input int px, input int py);
        int e;
        e = (px < COLS * CPX && py < ROWS * CPX) ? int'(mdl[py / CPX][px / CPX]) : 0;
        x = 10'(px);
        y = 10'(py);
        tick();
        checkOutput($sformatf("cell_on_x%0d_y%0d", px, py), int'(cell_on0), e);
    endtask

    task automatic checkGrid();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) checkPixel(c * CPX + CPX / 2, r * CPX + CPX / 2);
    endtask

    always @(negedge VGA_CLK_n) begin
        if (iRST_n && lines_pulse0) begin
            if (q_lines0.size() == 0) checkOutput("pulse0_unexpected", 1, 0);
            else begin
                checkOutput("pulse0_lines", int'(lines_cnt0), q_lines0.pop_front());
                checkOutput("pulse0_score", int'(score0), q_score0.pop_front());
            end
        end
        if (iRST_n && lines_pulse1) begin
            if (q_lines1.size() == 0) checkOutput("pulse1_unexpected", 1, 0);
            else begin
                checkOutput("pulse1_lines", int'(lines_cnt1), q_lines1.pop_front());
                checkOutput("pulse1_score", int'(score1), q_score1.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int n, cost;
        int exp1[3];
        int miss[$];
        exp1 = '{3, 6, 7};

        repeat (2) tick();
        iRST_n = 1'b1;
        tick();

        // Random content, then a reset landing in the middle of a clear scan.
        for (int i = 0; i < 3; i++) begin
            setPiece($urandom_range(9, 0), $urandom_range(9, 4), $urandom_range(9, 0), $urandom_range(9, 4),
                     $urandom_range(9, 0), $urandom_range(9, 4), $urandom_range(9, 0), $urandom_range(9, 4));
            lockPiece();
        end
        setPiece(0, 10, 1, 10, 0, 11, 1, 11);
        startLock(0);
        tick();
        iRST_n = 1'b0;
        repeat (2) tick();
        checkOutput("rst_busy", int'(busy0), 0);
        checkOutput("rst_score", int'(score0), 0);
        checkOutput("rst_game_over", int'(game_over0), 0);
        checkOutput("rst_lines_cnt", int'(lines_cnt0), 0);
        checkOutput("rst_flags", flagsOf(0), 0);
        checkOutput("rst_busy1", int'(busy1), 0);
        iRST_n = 1'b1;
        foreach (mdl[r, c]) mdl[r][c] = 1'b0;
        mdl_go = 1'b0;
        mdl_score = 0;
        checkGrid();

        // O piece in the bottom-left corner.
        setPiece(0, 10, 1, 10, 0, 11, 1, 11);
        applyStimulus("O_corner");
        lockPiece();
        checkPixel(0, 400);
        checkPixel(79, 479);
        checkPixel(80, 400);
        checkPixel(0, 399);
        checkPixel(400, 440);
        checkPixel(20, 480);

        setPiece(4, 3, 5, 3, 6, 3, 7, 3);
        applyStimulus("float");
        setPiece(0, 9, 1, 9, 2, 9, 3, 9);
        applyStimulus("on_O");
        setPiece(9, 5, 10, 5, 9, 6, 9, 7);
        applyStimulus("oob");
        setPiece(2, 10, 3, 10, 2, 11, 3, 11);
        applyStimulus("left_block");

        // Single-row clear completed by a horizontal I.
        setPiece(2, 11, 3, 11, 4, 11, 5, 11);
        lockPiece();
        setPiece(6, 11, 7, 11, 8, 11, 9, 11);
        applyStimulus("I_slot");
        lockPiece();
        checkGrid();

        // Rows 8..11 full except column 9, then a vertical I clears all four.
        for (int r = 8; r < ROWS; r++) begin
            miss.delete();
            for (int c = 0; c < COLS - 1; c++) if (!mdl[r][c]) miss.push_back(c);
            while (miss.size() > 0) begin
                int cs[4];
                for (int k = 0; k < 4; k++) cs[k] = (k < miss.size()) ? miss[k] : miss[miss.size() - 1];
                setPiece(cs[0], r, cs[1], r, cs[2], r, cs[3], r);
                lockPiece();
                for (int k = 0; k < 4 && miss.size() > 0; k++) void'(miss.pop_front());
            end
        end
        setPiece(9, 8, 9, 9, 9, 10, 9, 11);
        applyStimulus("I_vertical");
        lockPiece();
        checkOutput("tetris_lines", int'(lines_cnt0), 4);
        checkGrid();

        // Top-row lock sets game_over, which then stays set.
        setPiece(3, 0, 4, 0, 3, 1, 4, 1);
        lockPiece();
        setPiece(1, 0, 2, 0, 1, 1, 2, 1);
        applyStimulus("right_block");
        setPiece(0, 11, 1, 11, 2, 11, 3, 11);
        lockPiece();
        checkOutput("game_over_sticky", int'(game_over0), 1);

        // A second request during a sequence must be dropped.
        setPiece(5, 11, 6, 11, 7, 11, 8, 11);
        startLock(0);
        mdlLock(n, cost);
        tick();
        setPiece(0, 5, 1, 5, 2, 5, 3, 5);
        startLock(0);
        waitIdle(0, ROWS + cost);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("no_requeue", int'(busy0), 0);
        end
        checkGrid();

        // Small board: three single-row clears worth 3 points each into a 3-bit score.
        for (int i = 0; i < 3; i++) begin
            setPiece(0, 7, 1, 7, 2, 7, 3, 7);
            startLock(1);
            waitIdle(1, 2 + 8);
            setPiece(4, 7, 5, 7, 5, 7, 5, 7);
            q_lines1.push_back(1);
            q_score1.push_back(exp1[i]);
            startLock(1);
            waitIdle(1, 2 + 8 + 9);
            checkOutput("d1_score", int'(score1), exp1[i]);
            checkOutput("d1_lines", int'(lines_cnt1), 1);
        end

        repeat (2) tick();
        checkOutput("pending_pulses0", q_lines0.size(), 0);
        checkOutput("pending_pulses1", q_lines1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
